// File: rtl/frame_vtimer_if.sv
// Video timing bundle: pixel enable in, raster counters and blank/sync/marker flags out.
interface frame_vtimer_if;
    logic       pxl_cen;
    logic [8:0] H;
    logic [8:0] V;
    logic       Hinit;
    logic       Vinit;
    logic       LHBL;
    logic       LVBL;
    logic       HS;
    logic       VS;

    modport master (
        input  pxl_cen,
        output H, V, Hinit, Vinit, LHBL, LVBL, HS, VS
    );

    modport slave (
        output pxl_cen,
        input  H, V, Hinit, Vinit, LHBL, LVBL, HS, VS
    );
endinterface

// File: rtl/frame_vtimer.sv
// Raster timing generator: 9-bit H/V pixel counters with blanking, sync and frame markers.
// Flags are decoded from the next counts so they share a register edge with H/V.
module frame_vtimer #(
    parameter logic [8:0] HCNT_END = 9'd383,
    parameter logic [8:0] HB_START = 9'd319,
    parameter logic [8:0] HB_END   = 9'd383,
    parameter logic [8:0] HS_START = 9'd336,
    parameter logic [8:0] HS_END   = 9'd367,
    parameter logic [8:0] VCNT_END = 9'd261,
    parameter logic [8:0] VB_START = 9'd239,
    parameter logic [8:0] VB_END   = 9'd261,
    parameter logic [8:0] VS_START = 9'd244,
    parameter logic [8:0] VS_END   = 9'd247
) (
    input  logic           clk,
    input  logic           rst,
    frame_vtimer_if.master vt
);

    logic [8:0] h_q, h_d;
    logic [8:0] v_q, v_d;
    logic       hinit_q, hinit_d;
    logic       vinit_q, vinit_d;
    logic       lhbl_q, lhbl_d;
    logic       lvbl_q, lvbl_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vt.pxl_cen) begin
            if (h_q == HCNT_END) begin
                h_d = 9'd0;
                v_d = (v_q == VCNT_END) ? 9'd0 : v_q + 9'd1;
            end else begin
                h_d = h_q + 9'd1;
            end
        end

        // Holding counts reproduce the current flags, so no enable gating is needed here.
        lhbl_d  = (h_d <= HB_START) || (h_d > HB_END);
        lvbl_d  = (v_d <= VB_START) || (v_d > VB_END);
        hs_d    = (h_d >= HS_START) && (h_d <= HS_END);
        vs_d    = (v_d >= VS_START) && (v_d <= VS_END);
        hinit_d = (h_d == HCNT_END);
        vinit_d = (h_d == HCNT_END) && (v_d == VCNT_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q     <= 9'd0;
            v_q     <= 9'd0;
            hinit_q <= 1'b0;
            vinit_q <= 1'b0;
            lhbl_q  <= 1'b1;
            lvbl_q  <= 1'b1;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hinit_q <= hinit_d;
            vinit_q <= vinit_d;
            lhbl_q  <= lhbl_d;
            lvbl_q  <= lvbl_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign vt.H     = h_q;
    assign vt.V     = v_q;
    assign vt.Hinit = hinit_q;
    assign vt.Vinit = vinit_q;
    assign vt.LHBL  = lhbl_q;
    assign vt.LVBL  = lvbl_q;
    assign vt.HS    = hs_q;
    assign vt.VS    = vs_q;

endmodule

// File: tb/tb_frame_vtimer.sv
// Directed bench for frame_vtimer: default raster instance plus a small 16x4 raster instance.
module tb_frame_vtimer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    frame_vtimer_if d_if ();
    frame_vtimer_if s_if ();

    frame_vtimer u_dflt (
        .clk (clk),
        .rst (rst),
        .vt  (d_if)
    );

    frame_vtimer #(
        .HCNT_END (9'd15),
        .HB_START (9'd9),
        .HB_END   (9'd15),
        .HS_START (9'd11),
        .HS_END   (9'd13),
        .VCNT_END (9'd3),
        .VB_START (9'd1),
        .VB_END   (9'd3),
        .VS_START (9'd2),
        .VS_END   (9'd2)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .vt  (s_if)
    );

    // Expected {Hinit, Vinit, LHBL, LVBL, HS, VS} for a given (h, v) position.
    function automatic logic [5:0] dflt_flags(input int h, input int v);
        return {h == 383, (h == 383) && (v == 261), (h <= 319) || (h > 383),
                (v <= 239) || (v > 261), (h >= 336) && (h <= 367), (v >= 244) && (v <= 247)};
    endfunction

    function automatic logic [5:0] small_flags(input int h, input int v);
        return {h == 15, (h == 15) && (v == 3), (h <= 9) || (h > 15),
                (v <= 1) || (v > 3), (h >= 11) && (h <= 13), v == 2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        d_if.pxl_cen = 1'b0;
        s_if.pxl_cen = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [5:0] f;
        d_if.pxl_cen = 1'b1;
        repeat (50) tick();
        d_if.pxl_cen = 1'b0;
        n_run++;
        if (d_if.H !== 9'd50) begin
            n_fail++;
            $display("FAIL pre_reset_h got %0d want 50", d_if.H);
        end
        #3;
        rst = 1'b1;
        #1;
        n_run++;
        if (d_if.H !== 9'd0) begin n_fail++; $display("FAIL rst_h got %0d want 0", d_if.H); end
        n_run++;
        if (d_if.V !== 9'd0) begin n_fail++; $display("FAIL rst_v got %0d want 0", d_if.V); end
        f = {d_if.Hinit, d_if.Vinit, d_if.LHBL, d_if.LVBL, d_if.HS, d_if.VS};
        n_run++;
        if (f !== 6'b001100) begin
            n_fail++;
            $display("FAIL rst_flags got %b want 001100", f);
        end
        #2;
        rst = 1'b0;
        repeat (100) tick();
        f = {d_if.Hinit, d_if.Vinit, d_if.LHBL, d_if.LVBL, d_if.HS, d_if.VS};
        n_run++;
        if (d_if.H !== 9'd0 || d_if.V !== 9'd0 || f !== 6'b001100) begin
            n_fail++;
            $display("FAIL idle_after_rst got h=%0d v=%0d f=%b want 0 0 001100", d_if.H, d_if.V, f);
        end
        d_if.pxl_cen = 1'b1;
        repeat (5) tick();
        d_if.pxl_cen = 1'b0;
        repeat (100) tick();
        n_run++;
        if (d_if.H !== 9'd5 || d_if.V !== 9'd0) begin
            n_fail++;
            $display("FAIL hold_cen_low got h=%0d v=%0d want 5 0", d_if.H, d_if.V);
        end
    endtask

    task automatic test_line_timing();
        int lhbl_cnt = 0;
        int hs_cnt = 0;
        int hinit_cnt = 0;
        int hinit_pos = -1;
        int hs_first = -1;
        logic [5:0] f;
        do_reset();
        for (int i = 0; i < 384; i++) begin
            f = {d_if.Hinit, d_if.Vinit, d_if.LHBL, d_if.LVBL, d_if.HS, d_if.VS};
            n_run++;
            if (d_if.H !== 9'(i) || d_if.V !== 9'd0 || f !== dflt_flags(i, 0)) begin
                n_fail++;
                $display("FAIL line_px%0d got h=%0d v=%0d f=%b want %0d 0 %b",
                         i, d_if.H, d_if.V, f, i, dflt_flags(i, 0));
            end
            if (d_if.LHBL) lhbl_cnt++;
            if (d_if.HS) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (d_if.Hinit) begin
                hinit_cnt++;
                hinit_pos = i;
            end
            d_if.pxl_cen = 1'b1;
            tick();
            d_if.pxl_cen = 1'b0;
            repeat (3) tick();
        end
        n_run++;
        if (lhbl_cnt != 320) begin n_fail++; $display("FAIL lhbl_count got %0d want 320", lhbl_cnt); end
        n_run++;
        if (hs_cnt != 32 || hs_first != 336) begin
            n_fail++;
            $display("FAIL hs_window got cnt=%0d first=%0d want 32 336", hs_cnt, hs_first);
        end
        n_run++;
        if (hinit_cnt != 1 || hinit_pos != 383) begin
            n_fail++;
            $display("FAIL hinit_pos got cnt=%0d pos=%0d want 1 383", hinit_cnt, hinit_pos);
        end
        f = {d_if.Hinit, d_if.Vinit, d_if.LHBL, d_if.LVBL, d_if.HS, d_if.VS};
        n_run++;
        if (d_if.H !== 9'd0 || d_if.V !== 9'd1 || f !== 6'b001100) begin
            n_fail++;
            $display("FAIL line_wrap got h=%0d v=%0d f=%b want 0 1 001100", d_if.H, d_if.V, f);
        end
    endtask

    task automatic test_frame_small();
        int waited = 0;
        int n_en = 0;
        int lhbl_cnt = 0;
        int lvbl_cnt = 0;
        int vs_cnt = 0;
        int h = 0;
        int v = 0;
        logic [5:0] f;
        do_reset();
        s_if.pxl_cen = 1'b1;
        while (s_if.Vinit !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        n_run++;
        if (s_if.Vinit !== 1'b1 || s_if.H !== 9'd15 || s_if.V !== 9'd3) begin
            n_fail++;
            $display("FAIL vinit_reach got vinit=%b h=%0d v=%0d want 1 15 3", s_if.Vinit, s_if.H, s_if.V);
        end
        n_run++;
        if (waited != 63) begin n_fail++; $display("FAIL first_vinit got %0d want 63", waited); end
        tick();
        n_en = 1;
        f = {s_if.Hinit, s_if.Vinit, s_if.LHBL, s_if.LVBL, s_if.HS, s_if.VS};
        n_run++;
        if (s_if.H !== 9'd0 || s_if.V !== 9'd0 || f !== 6'b001100) begin
            n_fail++;
            $display("FAIL frame_wrap got h=%0d v=%0d f=%b want 0 0 001100", s_if.H, s_if.V, f);
        end
        while (n_en <= 200) begin
            f = {s_if.Hinit, s_if.Vinit, s_if.LHBL, s_if.LVBL, s_if.HS, s_if.VS};
            n_run++;
            if (s_if.H !== 9'(h) || s_if.V !== 9'(v) || f !== small_flags(h, v)) begin
                n_fail++;
                $display("FAIL small_px h%0d_v%0d got h=%0d v=%0d f=%b want %b",
                         h, v, s_if.H, s_if.V, f, small_flags(h, v));
            end
            if (s_if.LHBL) lhbl_cnt++;
            if (s_if.LVBL) lvbl_cnt++;
            if (s_if.VS) vs_cnt++;
            if (s_if.Vinit) break;
            tick();
            n_en++;
            h = (h == 15) ? 0 : h + 1;
            if (h == 0) v = (v == 3) ? 0 : v + 1;
        end
        s_if.pxl_cen = 1'b0;
        n_run++;
        if (n_en != 64) begin n_fail++; $display("FAIL frame_len got %0d want 64", n_en); end
        n_run++;
        if (lhbl_cnt != 40 || lvbl_cnt != 32 || vs_cnt != 16) begin
            n_fail++;
            $display("FAIL small_counts got lhbl=%0d lvbl=%0d vs=%0d want 40 32 16",
                     lhbl_cnt, lvbl_cnt, vs_cnt);
        end
    endtask

    task automatic test_gating();
        int k = 0;
        int h;
        int v;
        logic c;
        logic [5:0] f;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            c = 1'($urandom_range(0, 1));
            s_if.pxl_cen = c;
            tick();
            if (c) k++;
            h = k % 16;
            v = (k / 16) % 4;
            f = {s_if.Hinit, s_if.Vinit, s_if.LHBL, s_if.LVBL, s_if.HS, s_if.VS};
            n_run++;
            if (s_if.H !== 9'(h) || s_if.V !== 9'(v) || f !== small_flags(h, v)) begin
                n_fail++;
                $display("FAIL gating_clk%0d got h=%0d v=%0d f=%b want %0d %0d %b",
                         i, s_if.H, s_if.V, f, h, v, small_flags(h, v));
            end
        end
        s_if.pxl_cen = 1'b0;
    endtask

    initial begin
        d_if.pxl_cen = 1'b0;
        s_if.pxl_cen = 1'b0;
        #12;
        rst = 1'b0;
        tick();
        test_reset();
        test_line_timing();
        test_frame_small();
        test_gating();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
